// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-read, single-write RAM.
// merge_be works on a fixed maximum width so the write and bypass paths share one definition.
package ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } ram_state_e;

    // Widest word merge_be supports; one enable bit per data bit is the worst case (BYTE_W = 1).
    localparam int unsigned MAX_W     = 128;
    localparam int unsigned MAX_IDX_W = 7;

    // Number of words addressed by an aw-bit address.
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    function automatic logic [MAX_W-1:0] merge_be(
        input logic [MAX_W-1:0] old_word,
        input logic [MAX_W-1:0] new_word,
        input logic [MAX_W-1:0] be,
        input int               byte_w
    );
        logic [MAX_W-1:0] res;
        int unsigned      lane;
        res = old_word;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            lane = i / int'(byte_w);
            if (be[lane[MAX_IDX_W-1:0]]) begin
                res[i[MAX_IDX_W-1:0]] = new_word[i[MAX_IDX_W-1:0]];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every address once after reset or on clear_req, holding busy high.
// The FSM state is brought out on a port so checkers can observe it directly.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int A_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_req,
    output logic               busy,
    output logic               clr_we,
    output logic [A_WIDTH-1:0] clr_addr,
    output ram_state_e         state
);

    ram_state_e         state_nx;
    logic [A_WIDTH-1:0] addr_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= addr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = clr_addr;
        busy     = 1'b0;
        clr_we   = 1'b0;
        case (state)
            ST_CLEAR: begin
                // clear_req is deliberately not looked at here: a pending clear is never extended.
                busy    = 1'b1;
                clr_we  = 1'b1;
                addr_nx = clr_addr + 1'b1;
                if (&clr_addr) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_nx = ST_CLEAR;
                    addr_nx  = '0;
                end
            end
            default: begin
                state_nx = ST_CLEAR;
                addr_nx  = '0;
            end
        endcase
    end

endmodule

// File: rtl/ram_nr1w.sv
// Single-clock RAM with one byte-enabled write port and N_READ registered read ports.
// The clear sequencer owns the write port while busy; user reads and writes are dropped then.
module ram_nr1w
    import ram_pkg::*;
#(
    parameter int                   D_WIDTH   = 16,
    parameter int                   A_WIDTH   = 4,
    parameter int                   N_READ    = 2,
    parameter int                   BYTE_W    = 8,
    parameter int                   BYPASS    = 1,
    parameter logic [D_WIDTH-1:0]   CLEAR_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_req,
    output logic                        busy,
    input  logic                        we,
    input  logic [A_WIDTH-1:0]          waddr,
    input  logic [D_WIDTH-1:0]          wdata,
    input  logic [D_WIDTH/BYTE_W-1:0]   wbe,
    input  logic [N_READ-1:0]           re,
    input  logic [N_READ*A_WIDTH-1:0]   raddr,
    output logic [N_READ*D_WIDTH-1:0]   rdata,
    output logic [N_READ-1:0]           rvalid
);

    localparam int          NB    = D_WIDTH / BYTE_W;
    localparam int unsigned A_MAX = depth_of(A_WIDTH);

    // Handshake: re[k] is a one-cycle strobe with no backpressure; rvalid[k] is high for exactly
    // the cycle after an accepted strobe, and rdata port k holds its value whenever rvalid[k] is low.

    logic               clr_we;
    logic [A_WIDTH-1:0] clr_addr;
    ram_state_e         fsm_state;

    ram_clear_seq #(
        .A_WIDTH (A_WIDTH)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .state     (fsm_state)
    );

    logic               user_we;
    logic               w_en;
    logic [A_WIDTH-1:0] w_addr;
    logic [D_WIDTH-1:0] w_data;
    logic [NB-1:0]      w_be;

    assign user_we = we & ~busy;

    always_comb begin
        w_en   = user_we;
        w_addr = waddr;
        w_data = wdata;
        w_be   = wbe;
        if (clr_we) begin
            w_en   = 1'b1;
            w_addr = clr_addr;
            w_data = CLEAR_VAL;
            w_be   = '1;
        end
    end

    logic [D_WIDTH-1:0] mem [A_MAX];

    // No reset on the array: its contents are defined only by the clear sequencer.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= D_WIDTH'(merge_be(MAX_W'(mem[w_addr]), MAX_W'(w_data),
                                             MAX_W'(w_be), BYTE_W));
        end
    end

    logic [D_WIDTH-1:0] rd_word [N_READ];

    always_comb begin
        for (int k = 0; k < N_READ; k++) begin
            rd_word[k] = mem[raddr[k*A_WIDTH +: A_WIDTH]];
            if ((BYPASS != 0) && user_we && (waddr == raddr[k*A_WIDTH +: A_WIDTH])) begin
                rd_word[k] = D_WIDTH'(merge_be(MAX_W'(rd_word[k]), MAX_W'(wdata),
                                               MAX_W'(wbe), BYTE_W));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= '0;
        end else begin
            for (int k = 0; k < N_READ; k++) begin
                rvalid[k] <= re[k] & ~busy;
                if (re[k] && !busy) begin
                    rdata[k*D_WIDTH +: D_WIDTH] <= rd_word[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_nr1w.sv
// Bench for ram_nr1w: a bypass and a non-bypass instance share one stimulus stream and are
// compared every cycle against an array model of memory before and after each write.
module tb_ram_nr1w;

    localparam int          DW    = 16;
    localparam int          AW    = 4;
    localparam int          NR    = 2;
    localparam int          BW    = 8;
    localparam int          NB    = DW / BW;
    localparam int          DEPTH = 16;
    localparam logic [15:0] CV    = 16'hA5A5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear_req;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NB-1:0]     wbe;
    logic [NR-1:0]     re;
    logic [NR*AW-1:0]  raddr;

    logic              busy_b, busy_n;
    logic [NR*DW-1:0]  rdata_b, rdata_n;
    logic [NR-1:0]     rvalid_b, rvalid_n;

    ram_nr1w #(.D_WIDTH(DW), .A_WIDTH(AW), .N_READ(NR), .BYTE_W(BW), .BYPASS(1), .CLEAR_VAL(CV))
    u_byp (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
    );

    ram_nr1w #(.D_WIDTH(DW), .A_WIDTH(AW), .N_READ(NR), .BYTE_W(BW), .BYPASS(0), .CLEAR_VAL(CV))
    u_nob (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_n),
        .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata_n), .rvalid(rvalid_n)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mdl_mem [DEPTH];
    int          clr_left;
    logic [15:0] last_b [NR];
    logic [15:0] last_n [NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: bypass reads see memory after this cycle's write, non-bypass reads see it before.
    task automatic model_and_check();
        logic [15:0] mem_before [DEPTH];
        logic [15:0] mem_after  [DEPTH];
        logic        busy_now;
        logic [NR-1:0] vld;
        logic [AW-1:0] ra;
        mem_before = mdl_mem;
        mem_after  = mdl_mem;
        busy_now   = (clr_left > 0);
        if (busy_now) begin
            mem_after[DEPTH - clr_left] = CV;
            clr_left--;
        end else begin
            if (we) begin
                for (int b = 0; b < NB; b++) begin
                    if (wbe[b]) mem_after[waddr][b*BW +: BW] = wdata[b*BW +: BW];
                end
            end
            if (clear_req) clr_left = DEPTH;
        end
        for (int k = 0; k < NR; k++) begin
            ra     = raddr[k*AW +: AW];
            vld[k] = re[k] && !busy_now;
            if (vld[k]) begin
                exp_q.push_back(mem_after[ra]);
                exp_q.push_back(mem_before[ra]);
            end
        end
        mdl_mem = mem_after;

        check("busy_byp", {31'b0, busy_b}, {31'b0, clr_left > 0});
        check("busy_nob", {31'b0, busy_n}, {31'b0, clr_left > 0});
        for (int k = 0; k < NR; k++) begin
            if (vld[k]) begin
                last_b[k] = exp_q.pop_front();
                last_n[k] = exp_q.pop_front();
            end
            check($sformatf("rvalid_byp%0d", k), {31'b0, rvalid_b[k]}, {31'b0, vld[k]});
            check($sformatf("rvalid_nob%0d", k), {31'b0, rvalid_n[k]}, {31'b0, vld[k]});
            check($sformatf("rdata_byp%0d", k), {16'b0, rdata_b[k*DW +: DW]}, {16'b0, last_b[k]});
            check($sformatf("rdata_nob%0d", k), {16'b0, rdata_n[k*DW +: DW]}, {16'b0, last_n[k]});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        re = '0; raddr = '0; clear_req = 1'b0;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        we = 1'b1; waddr = a; wdata = d; wbe = be;
    endtask

    task automatic drive_read(input int k, input logic [AW-1:0] a);
        re[k] = 1'b1;
        raddr[k*AW +: AW] = a;
    endtask

    // Inputs are set at the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        model_and_check();
        @(negedge clk);
        set_idle();
    endtask

    task automatic assert_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_rdata_byp"}, {{(32-NR*DW){1'b0}}, rdata_b}, 32'h0);
        check({tag, "_rdata_nob"}, {{(32-NR*DW){1'b0}}, rdata_n}, 32'h0);
        check({tag, "_rvalid"}, {30'b0, rvalid_b | rvalid_n}, 32'h0);
        check({tag, "_busy"}, {31'b0, busy_b & busy_n}, 32'h1);
        clr_left = DEPTH;
        for (int k = 0; k < NR; k++) begin
            last_b[k] = '0;
            last_n[k] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1;
        set_idle();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        clr_left = 0;
        @(negedge clk);
        assert_reset("rst");

        // 1: clear after reset, then sweep every word on port 0
        repeat (DEPTH) cycle();
        for (int a = 0; a < DEPTH; a++) begin
            drive_read(0, AW'(a));
            cycle();
            check("t1_word", {16'b0, rdata_b[15:0]}, {16'b0, CV});
        end
        cycle();

        // 2: partial-lane write merges with the earlier full write
        drive_write(4'd3, 16'h1234, 2'b11); cycle();
        drive_write(4'd3, 16'hABCD, 2'b01); cycle();
        drive_read(1, 4'd3); cycle();
        check("t2_lane", {16'b0, rdata_b[31:16]}, 32'h12CD);

        // 3/4: read-during-write on both ports, with and without bypass
        drive_write(4'd5, 16'h0000, 2'b11); cycle();
        drive_write(4'd5, 16'hBEEF, 2'b10); drive_read(0, 4'd5); drive_read(1, 4'd5); cycle();
        check("t3_byp0", {16'b0, rdata_b[15:0]},  32'hBE00);
        check("t3_byp1", {16'b0, rdata_b[31:16]}, 32'hBE00);
        check("t4_nob0", {16'b0, rdata_n[15:0]},  32'h0000);
        check("t4_nob1", {16'b0, rdata_n[31:16]}, 32'h0000);
        drive_read(0, 4'd5); cycle();
        check("t4_next", {16'b0, rdata_n[15:0]}, 32'hBE00);

        // 5: clear_req together with a write; reads are ignored while busy
        drive_write(4'd2, 16'h7777, 2'b11); drive_read(0, 4'd2); clear_req = 1'b1; cycle();
        for (int i = 0; i < DEPTH; i++) begin
            re = 2'b11; raddr = NR*AW'($urandom);
            clear_req = ($urandom_range(0, 1) == 1);
            cycle();
            check("t5_rvalid", {30'b0, rvalid_b}, 32'h0);
        end
        drive_read(0, 4'd2); cycle();
        check("t5_clear", {16'b0, rdata_b[15:0]}, {16'b0, CV});

        // 6: reset part-way through a clear restarts it from address 0
        drive_write(4'd9, 16'h1111, 2'b11); cycle();
        clear_req = 1'b1; cycle();
        repeat (7) cycle();
        assert_reset("t6");
        repeat (DEPTH) cycle();
        for (int a = 0; a < DEPTH; a++) begin
            drive_read(0, AW'(a)); drive_read(1, AW'(DEPTH - 1 - a));
            cycle();
            check("t6_word0", {16'b0, rdata_b[15:0]},  {16'b0, CV});
            check("t6_word1", {16'b0, rdata_n[31:16]}, {16'b0, CV});
        end

        // Random traffic with frequent address collisions and rare clears
        for (int i = 0; i < 400; i++) begin
            we    = ($urandom_range(0, 2) != 0);
            waddr = AW'($urandom_range(0, DEPTH - 1));
            wdata = DW'($urandom);
            wbe   = NB'($urandom_range(0, 3));
            re    = NR'($urandom_range(0, 3));
            for (int k = 0; k < NR; k++) begin
                raddr[k*AW +: AW] = ($urandom_range(0, 1) == 1) ? waddr
                                                                 : AW'($urandom_range(0, DEPTH - 1));
            end
            clear_req = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
